// File: rtl/uart_fifo_pkg.sv
// Shared types and constants for the UART TX FIFO scheduler.
// State codes are fixed so they can be matched against waveforms and other tools.
package uart_fifo_pkg;

  localparam int unsigned DATA_W = 8;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] POP   = 3'd1;
  localparam logic [2:0] START = 3'd2;
  localparam logic [2:0] WAIT  = 3'd3;
  localparam logic [2:0] GAP   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = IDLE,
    ST_POP   = POP,
    ST_START = START,
    ST_WAIT  = WAIT,
    ST_GAP   = GAP
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for the remote clear-to-send line.
// Compiled only when UART_TX_SCHED_CTS_EN is defined.
`ifdef UART_TX_SCHED_CTS_EN
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule
`endif

// File: rtl/uart_tx_fifo_sched.sv
// Drains a byte FIFO into a UART transmitter with inter-byte gap, watchdog and sent counter.
// Optional clear-to-send gating is enabled with UART_TX_SCHED_CTS_EN.
module uart_tx_fifo_sched
  import uart_fifo_pkg::*;
#(
  parameter int unsigned GAP_CYCLES     = 0,
  parameter int unsigned TIMEOUT_CYCLES = 200000,
  parameter int unsigned CNT_W          = 16
) (
`ifdef UART_TX_SCHED_CTS_EN
  input  logic              cts_n,
`endif
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_pop,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_start,
  input  logic              tx_done,
  output logic              busy,
  output logic [CNT_W-1:0]  sent_cnt,
  output logic              timeout_err,
  input  logic              clr_err
);

  localparam int unsigned WD_W     = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam bit          HAS_GAP  = (GAP_CYCLES > 0);

  localparam logic [WD_W-1:0]  WD_END  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_END = GAP_W'(GAP_LAST);

  state_t             state;
  logic [WD_W-1:0]    wd_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic               cts_ok;

`ifdef UART_TX_SCHED_CTS_EN
  logic cts_sync;

  // Idle-high reset keeps the link blocked until the remote end asserts CTS.
  sync_2ff #(
    .RST_VAL(1'b1)
  ) u_cts_sync (
    .clk (clk),
    .rst (rst),
    .d   (cts_n),
    .q   (cts_sync)
  );

  assign cts_ok = ~cts_sync;
`else
  assign cts_ok = 1'b1;
`endif

  // Byte scheduler; every output is a register updated alongside the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      tx_data     <= '0;
      sent_cnt    <= '0;
      timeout_err <= 1'b0;
      fifo_pop    <= 1'b0;
      tx_start    <= 1'b0;
      busy        <= 1'b0;
      wd_cnt      <= '0;
      gap_cnt     <= '0;
    end else begin
      fifo_pop <= 1'b0;
      tx_start <= 1'b0;
      // A timeout later in this block overrides a simultaneous clear.
      if (clr_err) begin
        timeout_err <= 1'b0;
      end

      unique case (state)
        ST_IDLE: begin
          if (en && !fifo_empty && cts_ok) begin
            tx_data  <= fifo_data;
            fifo_pop <= 1'b1;
            busy     <= 1'b1;
            state    <= ST_POP;
          end
        end

        ST_POP: begin
          tx_start <= 1'b1;
          state    <= ST_START;
        end

        ST_START: begin
          wd_cnt <= '0;
          state  <= ST_WAIT;
        end

        ST_WAIT: begin
          if (tx_done) begin
            sent_cnt <= sent_cnt + CNT_W'(1);
            gap_cnt  <= '0;
            if (HAS_GAP) begin
              state <= ST_GAP;
            end else begin
              busy  <= 1'b0;
              state <= ST_IDLE;
            end
          end else if (wd_cnt == WD_END) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            state       <= ST_IDLE;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
        end

        ST_GAP: begin
          if (gap_cnt == GAP_END) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_sched.sv
// Directed bench for uart_tx_fifo_sched: instance A has no gap and a short watchdog,
// instance B has a 3-cycle gap; both share the FIFO stimulus but have separate enables.
module tb_uart_tx_fifo_sched;

  logic       clk;
  logic       rst;
  logic       en_a, en_b;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       clr_err;
  logic       done_a, done_b;

  logic       pop_a, start_a, busy_a, err_a;
  logic [7:0] txd_a;
  logic [3:0] cnt_a;
  logic       pop_b, start_b, busy_b, err_b;
  logic [7:0] txd_b;
  logic [15:0] cnt_b;

  int         n_checks;
  int         n_fail;
  logic [3:0] exp_a;
  logic [15:0] exp_b;

  uart_tx_fifo_sched #(
    .GAP_CYCLES(0),
    .TIMEOUT_CYCLES(50),
    .CNT_W(4)
  ) dut_a (
`ifdef UART_TX_SCHED_CTS_EN
    .cts_n       (1'b0),
`endif
    .clk         (clk),
    .rst         (rst),
    .en          (en_a),
    .fifo_empty  (fifo_empty),
    .fifo_data   (fifo_data),
    .fifo_pop    (pop_a),
    .tx_data     (txd_a),
    .tx_start    (start_a),
    .tx_done     (done_a),
    .busy        (busy_a),
    .sent_cnt    (cnt_a),
    .timeout_err (err_a),
    .clr_err     (clr_err)
  );

  uart_tx_fifo_sched #(
    .GAP_CYCLES(3),
    .TIMEOUT_CYCLES(1000),
    .CNT_W(16)
  ) dut_b (
`ifdef UART_TX_SCHED_CTS_EN
    .cts_n       (1'b0),
`endif
    .clk         (clk),
    .rst         (rst),
    .en          (en_b),
    .fifo_empty  (fifo_empty),
    .fifo_data   (fifo_data),
    .fifo_pop    (pop_b),
    .tx_data     (txd_b),
    .tx_start    (start_b),
    .tx_done     (done_b),
    .busy        (busy_b),
    .sent_cnt    (cnt_b),
    .timeout_err (err_b),
    .clr_err     (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "bench did not finish");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [31:0] f_pop(input bit sel);
    return sel ? 32'(pop_b) : 32'(pop_a);
  endfunction

  function automatic logic [31:0] f_start(input bit sel);
    return sel ? 32'(start_b) : 32'(start_a);
  endfunction

  function automatic logic [31:0] f_busy(input bit sel);
    return sel ? 32'(busy_b) : 32'(busy_a);
  endfunction

  function automatic logic [31:0] f_txd(input bit sel);
    return sel ? 32'(txd_b) : 32'(txd_a);
  endfunction

  function automatic logic [31:0] f_cnt(input bit sel);
    return sel ? 32'(cnt_b) : 32'(cnt_a);
  endfunction

  task automatic set_done(input bit sel, input logic v);
    if (sel) done_b = v;
    else     done_a = v;
  endtask

  // Advance until the selected DUT pops (bounded) and check the latency.
  task automatic wait_pop(input bit sel, input int exp_lat);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (f_pop(sel) == 0 && n < 40);
    check("pop_latency", 32'(n), 32'(exp_lat));
  endtask

  // One complete byte: pop, start, hold, done pulse, counter update.
  task automatic xfer(input bit sel, input logic [7:0] b, input int exp_lat,
                      input bit has_next, input logic [7:0] nxt, input int hold,
                      input bit drop_en);
    wait_pop(sel, exp_lat);
    check("tx_data_capture", f_txd(sel), 32'(b));
    if (has_next) fifo_data = nxt;
    else          fifo_empty = 1'b1;
    tick();
    check("tx_start", f_start(sel), 32'd1);
    check("pop_one_cycle", f_pop(sel), 32'd0);
    for (int i = 0; i < hold; i++) begin
      if (drop_en && i == 0) begin
        if (sel) en_b = 1'b0;
        else     en_a = 1'b0;
      end
      tick();
      check("tx_data_hold", f_txd(sel), 32'(b));
      check("busy_in_wait", f_busy(sel), 32'd1);
      check("start_one_cycle", f_start(sel), 32'd0);
    end
    set_done(sel, 1'b1);
    tick();
    set_done(sel, 1'b0);
    if (sel) begin
      exp_b = exp_b + 16'd1;
      check("sent_cnt_b", f_cnt(1'b1), 32'(exp_b));
    end else begin
      exp_a = exp_a + 4'd1;
      check("sent_cnt_a", f_cnt(1'b0), 32'(exp_a));
    end
  endtask

  initial begin
    logic seen;
    n_checks   = 0;
    n_fail     = 0;
    exp_a      = '0;
    exp_b      = '0;
    rst        = 1'b0;
    en_a       = 1'b0;
    en_b       = 1'b0;
    fifo_empty = 1'b1;
    fifo_data  = 8'h00;
    clr_err    = 1'b0;
    done_a     = 1'b0;
    done_b     = 1'b0;

    // Reset values
    repeat (3) tick();
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_pop", 32'(pop_a), 32'd0);
    check("rst_start", 32'(start_a), 32'd0);
    check("rst_txd", 32'(txd_a), 32'd0);
    check("rst_cnt", 32'(cnt_a), 32'd0);
    check("rst_err", 32'(err_a), 32'd0);
    check("rst_busy_b", 32'(busy_b), 32'd0);

    // Enabled but empty FIFO: nothing happens
    rst  = 1'b1;
    en_a = 1'b1;
    en_b = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      tick();
      seen = seen | pop_a | pop_b | start_a | start_b | busy_a | busy_b;
    end
    check("idle_quiet", 32'(seen), 32'd0);
    check("idle_cnt_a", 32'(cnt_a), 32'd0);
    check("idle_cnt_b", 32'(cnt_b), 32'd0);

    // tx_done outside WAIT is ignored
    done_a = 1'b1;
    tick();
    done_a = 1'b0;
    check("stray_done_cnt", 32'(cnt_a), 32'd0);
    check("stray_done_busy", 32'(busy_a), 32'd0);
    en_b = 1'b0;

    // Single byte, done 10 cycles after start
    fifo_data  = 8'hA5;
    fifo_empty = 1'b0;
    xfer(1'b0, 8'hA5, 1, 1'b0, 8'h00, 10, 1'b0);
    check("single_idle_after", 32'(busy_a), 32'd0);

    // Back-to-back with no gap: pop one cycle after the done edge
    fifo_data  = 8'h5A;
    fifo_empty = 1'b0;
    xfer(1'b0, 8'h5A, 1, 1'b1, 8'hC3, 5, 1'b0);
    xfer(1'b0, 8'hC3, 1, 1'b0, 8'h00, 5, 1'b0);

    // en dropped during WAIT with a second byte queued
    fifo_data  = 8'h01;
    fifo_empty = 1'b0;
    xfer(1'b0, 8'h01, 1, 1'b1, 8'h02, 5, 1'b1);
    seen = 1'b0;
    repeat (20) begin
      tick();
      seen = seen | pop_a | busy_a;
    end
    check("en_low_no_pop", 32'(seen), 32'd0);
    check("en_low_cnt", 32'(cnt_a), 32'd4);
    en_a = 1'b1;
    xfer(1'b0, 8'h02, 1, 1'b0, 8'h00, 3, 1'b0);

    // Watchdog: 50 WAIT cycles without done
    fifo_data  = 8'h77;
    fifo_empty = 1'b0;
    wait_pop(1'b0, 1);
    fifo_empty = 1'b1;
    tick();
    check("to_start", 32'(start_a), 32'd1);
    repeat (50) tick();
    check("to_not_yet", 32'(err_a), 32'd0);
    check("to_busy_wait", 32'(busy_a), 32'd1);
    tick();
    check("to_err_set", 32'(err_a), 32'd1);
    check("to_idle", 32'(busy_a), 32'd0);
    check("to_cnt_same", 32'(cnt_a), 32'd5);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("to_err_clr", 32'(err_a), 32'd0);

    // Timeout and clr_err on the same edge: the set wins
    fifo_data  = 8'h78;
    fifo_empty = 1'b0;
    wait_pop(1'b0, 1);
    fifo_empty = 1'b1;
    tick();
    repeat (50) tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("set_wins", 32'(err_a), 32'd1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("set_wins_clr", 32'(err_a), 32'd0);

    // 11 more bytes take the 4-bit counter from 5 through 15 and wrap to 0
    fifo_data  = 8'hE0;
    fifo_empty = 1'b0;
    for (int i = 0; i < 11; i++) begin
      xfer(1'b0, 8'(8'hE0 + i), 1, (i < 10), 8'(8'hE1 + i), 2, 1'b0);
      if (i == 9) check("cnt_all_ones", 32'(cnt_a), 32'hF);
    end
    check("cnt_wrap", 32'(cnt_a), 32'd0);

    // Burst of four on instance B with a 3-cycle gap
    en_a       = 1'b0;
    en_b       = 1'b1;
    fifo_data  = 8'h11;
    fifo_empty = 1'b0;
    xfer(1'b1, 8'h11, 1, 1'b1, 8'h22, 4, 1'b0);
    xfer(1'b1, 8'h22, 4, 1'b1, 8'h33, 4, 1'b0);
    xfer(1'b1, 8'h33, 4, 1'b1, 8'h44, 4, 1'b0);
    xfer(1'b1, 8'h44, 4, 1'b0, 8'h00, 4, 1'b0);
    check("gap_busy_0", 32'(busy_b), 32'd1);
    tick();
    tick();
    check("gap_busy_2", 32'(busy_b), 32'd1);
    tick();
    check("gap_done_idle", 32'(busy_b), 32'd0);
    check("burst_cnt", 32'(cnt_b), 32'd4);

    // Reset mid-byte aborts at once
    en_b       = 1'b0;
    en_a       = 1'b1;
    fifo_data  = 8'h99;
    fifo_empty = 1'b0;
    tick();
    check("mid_pop", 32'(pop_a), 32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy_a), 32'd0);
    check("mid_rst_pop", 32'(pop_a), 32'd0);
    check("mid_rst_txd", 32'(txd_a), 32'd0);
    check("mid_rst_cnt_b", 32'(cnt_b), 32'd0);
    fifo_empty = 1'b1;
    tick();
    rst = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
